fsm7_resp_checker: RTL and testbench

- Receiving-end monitor for the 2-bit Mealy encoder FSM (4 states, input a, registered output y).
- Holds a cycle-accurate shadow copy of the encoder's transition/output function and tracks the encoder from the same enable/a stream.
- Predicts each registered y and compares it with the y returned by the encoder.
- Reports mismatches through a pulse, a sticky flag, saturating counters and a first-error capture; sits beside the encoder in the SoC test path.

---
 rtl/fsm7_resp_checker.sv | 150 +++++++++++++++
 tb/tb_fsm7_resp_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fsm7_resp_checker.sv
// Response checker for the 2-bit Mealy encoder: shadows the encoder from the same
// enable/a stream, predicts each registered y and logs mismatches.
module fsm7_resp_checker #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       a,
  input  logic [1:0]       y,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic [1:0]       first_state,
  output logic [1:0]       first_a,
  output logic [1:0]       first_exp,
  output logic [1:0]       first_got,
  output logic [1:0]       model_state,
  output logic             halted
);

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_HALT = 2'd2
  } ctrl_t;

  ctrl_t      ctrl_state;
  logic       pending;
  logic [1:0] exp_q;
  logic [3:0] ctx_q;
  logic [3:0] lut_out;
  logic       mismatch;

  // Encoder transition/output table, packed as {next_state, y}.
  function automatic logic [3:0] enc_lut(input logic [1:0] s, input logic [1:0] sym);
    logic [3:0] r;
    case ({s, sym})
      4'b00_00: r = {2'd1, 2'd2};
      4'b00_01: r = {2'd2, 2'd0};
      4'b00_10: r = {2'd3, 2'd2};
      4'b00_11: r = {2'd1, 2'd0};
      4'b01_00: r = {2'd1, 2'd1};
      4'b01_01: r = {2'd2, 2'd2};
      4'b01_10: r = {2'd2, 2'd0};
      4'b01_11: r = {2'd0, 2'd0};
      4'b10_00: r = {2'd1, 2'd3};
      4'b10_01: r = {2'd3, 2'd2};
      4'b10_10: r = {2'd1, 2'd0};
      4'b10_11: r = {2'd2, 2'd2};
      4'b11_00: r = {2'd3, 2'd3};
      4'b11_01: r = {2'd2, 2'd1};
      4'b11_10: r = {2'd3, 2'd0};
      default:  r = {2'd2, 2'd3};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lut_out  = enc_lut(model_state, a);
  assign mismatch = (y != exp_q);

  // Prediction stage: captured alongside the model step, consumed one edge later.
  always_ff @(posedge clock) begin
    if (enable) begin
      exp_q <= lut_out[1:0];
      ctx_q <= {model_state, a};
    end
  end

  // Shadow model and pending flag; these keep tracking regardless of control state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_state <= 2'd0;
      pending     <= 1'b0;
    end else begin
      if (enable) model_state <= lut_out[3:2];
      pending <= enable;
    end
  end

  // Control FSM with compare/log stage; clear wins over a same-edge compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_state  <= CTRL_IDLE;
      halted      <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      chk_count   <= '0;
      first_state <= 2'd0;
      first_a     <= 2'd0;
      first_exp   <= 2'd0;
      first_got   <= 2'd0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        ctrl_state  <= CTRL_IDLE;
        halted      <= 1'b0;
        err_sticky  <= 1'b0;
        err_count   <= '0;
        chk_count   <= '0;
        first_state <= 2'd0;
        first_a     <= 2'd0;
        first_exp   <= 2'd0;
        first_got   <= 2'd0;
      end else begin
        case (ctrl_state)
          CTRL_IDLE: begin
            if (enable) ctrl_state <= CTRL_RUN;
          end
          CTRL_RUN: begin
            if (pending) begin
              chk_count <= sat_inc(chk_count);
              if (mismatch) begin
                err_pulse <= 1'b1;
                err_count <= sat_inc(err_count);
                if (!err_sticky) begin
                  err_sticky  <= 1'b1;
                  first_state <= ctx_q[3:2];
                  first_a     <= ctx_q[1:0];
                  first_exp   <= exp_q;
                  first_got   <= y;
                end
                if (STOP_ON_ERR) begin
                  ctrl_state <= CTRL_HALT;
                  halted     <= 1'b1;
                end
              end
            end
          end
          CTRL_HALT: begin
            halted <= 1'b1;
          end
          default: begin
            ctrl_state <= CTRL_IDLE;
            halted     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsm7_resp_checker.sv
// Directed bench for fsm7_resp_checker: a vector table for the main stream plus
// hand-written sequences for halt, enable gaps, saturation and mid-stream reset.
module tb_fsm7_resp_checker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       enable;
  logic [1:0] a;
  logic [1:0] y;

  logic       p0, s0, p1, s1, p2, s2, h0, h1, h2;
  logic [7:0] e0, c0, e1, c1;
  logic [1:0] e2, c2;
  logic [1:0] fs0, fa0, fe0, fg0, fs1, fa1, fe1, fg1, fs2, fa2, fe2, fg2;
  logic [1:0] m0, m1, m2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fsm7_resp_checker dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .a(a), .y(y),
    .err_pulse(p0), .err_sticky(s0), .err_count(e0), .chk_count(c0),
    .first_state(fs0), .first_a(fa0), .first_exp(fe0), .first_got(fg0),
    .model_state(m0), .halted(h0));

  fsm7_resp_checker #(.STOP_ON_ERR(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .a(a), .y(y),
    .err_pulse(p1), .err_sticky(s1), .err_count(e1), .chk_count(c1),
    .first_state(fs1), .first_a(fa1), .first_exp(fe1), .first_got(fg1),
    .model_state(m1), .halted(h1));

  fsm7_resp_checker #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable), .a(a), .y(y),
    .err_pulse(p2), .err_sticky(s2), .err_count(e2), .chk_count(c2),
    .first_state(fs2), .first_a(fa2), .first_exp(fe2), .first_got(fg2),
    .model_state(m2), .halted(h2));

  typedef struct {
    logic       en;
    logic [1:0] a;
    logic [1:0] y;
    logic       clr;
    logic [1:0] ms;
    logic       pulse;
    int         err;
    int         chk;
    logic       sticky;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int en, input int av, input int yv, input int clr,
                     input int ms, input int pulse, input int err, input int chk,
                     input int sticky);
    vec_t v;
    v.en = en[0]; v.a = av[1:0]; v.y = yv[1:0]; v.clr = clr[0];
    v.ms = ms[1:0]; v.pulse = pulse[0]; v.err = err; v.chk = chk; v.sticky = sticky[0];
    tbl.push_back(v);
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
  task automatic step(input logic en, input logic [1:0] av, input logic [1:0] yv,
                      input logic clr);
    enable = en; a = av; y = yv; clear = clr;
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0; a = 2'd0; y = 2'd0;
    #12;
    check("rst_model", int'(m0), 0);
    check("rst_counts", int'(e0) + int'(c0) + int'(e2) + int'(c2), 0);
    check("rst_flags", int'({p0, s0, h0, h1}), 0);
    check("rst_capture", int'({fs0, fa0, fe0, fg0}), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Clean stream a=0,1,0,3, then clear, then the same stream with y=1 on the 2nd compare.
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 1, 2, 0,  2, 0, 0, 1, 0);
    add(1, 0, 2, 0,  1, 0, 0, 2, 0);
    add(1, 3, 3, 0,  0, 0, 0, 3, 0);
    add(0, 0, 0, 0,  0, 0, 0, 4, 0);
    add(0, 0, 0, 0,  0, 0, 0, 4, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 1, 2, 0,  2, 0, 0, 1, 0);
    add(1, 0, 1, 0,  1, 1, 1, 2, 1);
    add(1, 3, 3, 0,  0, 0, 1, 3, 1);
    add(0, 0, 0, 0,  0, 0, 1, 4, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].a, tbl[i].y, tbl[i].clr);
      check($sformatf("v%0d_state", i), int'(m0), int'(tbl[i].ms));
      check($sformatf("v%0d_pulse", i), int'(p0), int'(tbl[i].pulse));
      check($sformatf("v%0d_err", i), int'(e0), tbl[i].err);
      check($sformatf("v%0d_chk", i), int'(c0), tbl[i].chk);
      check($sformatf("v%0d_sticky", i), int'(s0), int'(tbl[i].sticky));
      check($sformatf("v%0d_halted", i), int'(h0), 0);
    end
    check("cap_state", int'(fs0), 1);
    check("cap_a", int'(fa0), 1);
    check("cap_exp", int'(fe0), 2);
    check("cap_got", int'(fg0), 1);
    check("halt_after_first", int'(h1), 1);
    check("halt_err", int'(e1), 1);
    check("halt_chk", int'(c1), 2);

    // Second injected error: dut0 logs it, halted dut1 ignores it but keeps tracking.
    step(1'b1, 2'd0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 2'd3, 1'b0);
    check("err2_pulse", int'(p0), 1);
    check("err2_count", int'(e0), 2);
    check("err2_chk", int'(c0), 5);
    check("err2_keep_cap", int'({fs0, fa0, fe0, fg0}), int'({2'd1, 2'd1, 2'd2, 2'd1}));
    check("halt_err_frozen", int'(e1), 1);
    check("halt_chk_frozen", int'(c1), 2);
    check("halt_pulse", int'(p1), 0);
    check("halt_model", int'(m1), 1);
    step(1'b0, 2'd0, 2'd1, 1'b0);
    check("post_err_match", int'(c0), 6);
    step(1'b0, 2'd0, 2'd1, 1'b1);
    check("clr_halted", int'(h1), 0);
    check("clr_counts", int'(e1) + int'(c1) + int'(e0) + int'(c0), 0);
    check("clr_sticky", int'({s0, s1}), 0);
    check("clr_capture", int'({fs1, fa1, fe1, fg1}), 0);
    check("clr_model_kept", int'(m0), 1);

    // Enable pattern 1,0,0,1 with y held at 2: exactly two compares.
    step(1'b1, 2'd1, 2'd0, 1'b0);
    check("gap_t1_state", int'(m0), 2);
    check("gap_t1_chk", int'(c0), 0);
    step(1'b0, 2'd1, 2'd2, 1'b0);
    check("gap_t2_chk", int'(c0), 1);
    step(1'b0, 2'd1, 2'd2, 1'b0);
    check("gap_t3_chk", int'(c0), 1);
    check("gap_t3_state", int'(m0), 2);
    step(1'b1, 2'd1, 2'd2, 1'b0);
    check("gap_t4_chk", int'(c0), 1);
    check("gap_t4_state", int'(m0), 3);
    step(1'b0, 2'd1, 2'd2, 1'b0);
    check("gap_t5_chk", int'(c0), 2);
    check("gap_t5_err", int'(e0), 0);

    // Five mismatches from S3 (a=0 keeps S3, expects y=3).
    step(1'b1, 2'd0, 2'd2, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 2'd0, 2'd0, 1'b0);
      check($sformatf("sat%0d_err2", k), int'(e2), (k < 3) ? k : 3);
      check($sformatf("sat%0d_pulse2", k), int'(p2), 1);
    end
    check("sat_chk2", int'(c2), 3);
    check("sat_err0", int'(e0), 5);
    check("sat_chk0", int'(c0), 7);
    check("sat_cap2", int'({fs2, fa2, fe2, fg2}), int'({2'd3, 2'd0, 2'd3, 2'd0}));
    check("sat_sticky2", int'(s2), 1);

    // Mid-stream reset after two enabled edges.
    step(1'b1, 2'd0, 2'd0, 1'b0);
    step(1'b1, 2'd1, 2'd3, 1'b0);
    check("pre_rst_state", int'(m0), 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", int'(m0), 0);
    check("mid_rst_counts", int'(e0) + int'(c0) + int'(e2) + int'(c2), 0);
    check("mid_rst_flags", int'({p0, s0, s2, h0}), 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 2'd2, 2'd0, 1'b0);
    check("post_rst_state", int'(m0), 3);
    check("post_rst_nochk", int'(c0), 0);
    step(1'b0, 2'd2, 2'd2, 1'b0);
    check("post_rst_chk", int'(c0), 1);
    check("post_rst_err", int'(e0), 0);
    check("post_rst_pulse", int'(p0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
